// File: rtl/seg7_bcd_conv.sv
// Binary to display-word converter feeding the 7-segment scanning PHY.
// Decimal mode runs a double-dabble engine; hex mode passes the value through.
module seg7_bcd_conv #(
  parameter int nr_digit = 8,
  parameter int nr_bits  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [nr_bits-1:0]    in_value,
  input  logic                  in_hex,
  output logic [4*nr_digit-1:0] data,
  output logic                  ovf,
  output logic                  busy,
  output logic                  done
);

  localparam int DW = 4 * nr_digit;
  localparam int CW = $clog2(nr_bits + 1);

  typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;

  // 10^nr_digit saturated at 2^nr_bits, so a limit no input can reach disables overflow.
  function automatic logic [nr_bits:0] dec_limit();
    logic [nr_bits+4:0] acc;
    logic [nr_bits+4:0] cap;
    cap = (nr_bits + 5)'(1) << nr_bits;
    acc = (nr_bits + 5)'(1);
    for (int i = 0; i < nr_digit; i++) begin
      acc = acc * (nr_bits + 5)'(10);
      if (acc > cap) acc = cap;
    end
    return acc[nr_bits:0];
  endfunction

  localparam logic [nr_bits:0] DEC_LIMIT = dec_limit();

  state_t              state_reg;
  logic [DW-1:0]       bcd_reg;
  logic [nr_bits-1:0]  shift_reg;
  logic [CW-1:0]       cnt_reg;
  logic [DW-1:0]       res_reg;
  logic                res_ovf_reg;

  logic [DW-1:0]       bcd_corr;
  logic [DW-1:0]       bcd_shifted;
  logic [DW-1:0]       hex_word;
  logic                hex_ovf;
  logic                dec_ovf;

  genvar gi;
  generate
    for (gi = 0; gi < nr_digit; gi++) begin : g_corr
      assign bcd_corr[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                   bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end

    if (nr_bits > DW) begin : g_trunc
      assign hex_word = in_value[DW-1:0];
      assign hex_ovf  = |in_value[nr_bits-1:DW];
    end else if (nr_bits == DW) begin : g_exact
      assign hex_word = in_value;
      assign hex_ovf  = 1'b0;
    end else begin : g_ext
      assign hex_word = {{(DW - nr_bits){1'b0}}, in_value};
      assign hex_ovf  = 1'b0;
    end
  endgenerate

  assign bcd_shifted = {bcd_corr[DW-2:0], shift_reg[nr_bits-1]};
  assign dec_ovf     = ({1'b0, in_value} >= DEC_LIMIT);

  assign in_ready = (state_reg == IDLE);
  assign busy     = !in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      bcd_reg     <= '0;
      shift_reg   <= '0;
      cnt_reg     <= '0;
      res_reg     <= '0;
      res_ovf_reg <= 1'b0;
      data        <= '0;
      ovf         <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            if (in_hex) begin
              res_reg     <= hex_word;
              res_ovf_reg <= hex_ovf;
              state_reg   <= FIN;
            end else if (dec_ovf) begin
              res_reg     <= {nr_digit{4'hE}};
              res_ovf_reg <= 1'b1;
              state_reg   <= FIN;
            end else begin
              bcd_reg     <= '0;
              shift_reg   <= in_value;
              cnt_reg     <= CW'(nr_bits);
              res_ovf_reg <= 1'b0;
              state_reg   <= CONV;
            end
          end
        end
        CONV: begin
          bcd_reg   <= bcd_shifted;
          shift_reg <= {shift_reg[nr_bits-2:0], 1'b0};
          cnt_reg   <= cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            res_reg   <= bcd_shifted;
            state_reg <= FIN;
          end
        end
        FIN: begin
          // The only edge where the display word changes outside reset.
          data      <= res_reg;
          ovf       <= res_ovf_reg;
          done      <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_bcd_conv.sv
// Randomized and directed checks of seg7_bcd_conv against a decimal/hex reference model.
module tb_seg7_bcd_conv;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_hex, ovf, busy, done;
  logic [31:0] in_value, data;

  logic        wide_valid, wide_ready, wide_hex, wide_ovf, wide_busy, wide_done;
  logic [35:0] wide_value;
  logic [31:0] wide_data;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seg7_bcd_conv #(.nr_digit(8), .nr_bits(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .in_hex(in_hex), .data(data), .ovf(ovf),
    .busy(busy), .done(done)
  );

  seg7_bcd_conv #(.nr_digit(8), .nr_bits(36)) u_wide (
    .clk(clk), .rst(rst), .in_valid(wide_valid), .in_ready(wide_ready),
    .in_value(wide_value), .in_hex(wide_hex), .data(wide_data), .ovf(wide_ovf),
    .busy(wide_busy), .done(wide_done)
  );

  // Reference: decimal digits by repeated division, hex by modulo 2^32.
  function automatic void ref_conv(input longint unsigned v, input bit hex,
                                   output logic [31:0] d, output logic o);
    longint unsigned t;
    if (hex) begin
      d = 32'(v % 64'h1_0000_0000);
      o = (v >= 64'h1_0000_0000);
    end else if (v >= 64'd100000000) begin
      d = 32'hEEEEEEEE;
      o = 1'b1;
    end else begin
      t = v;
      d = '0;
      for (int i = 0; i < 8; i++) begin
        d[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
      o = 1'b0;
    end
  endfunction

  task automatic run_one(input longint unsigned v, input bit hex, input string tag);
    logic [31:0] ed, prev;
    logic        eo;
    int          exp_lat, lat, guard;
    bit          hold_ok, ready_ok;
    ref_conv(v, hex, ed, eo);
    exp_lat = (hex || v >= 64'd100000000) ? 1 : 33;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL %s ready_wait: in_ready=%b required 1", tag, in_ready);
    end
    prev     = data;
    in_valid = 1'b1;
    in_value = 32'(v);
    in_hex   = hex;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ready_after_accept: got %b required 0", tag, in_ready);
    end
    lat = 0; hold_ok = 1; ready_ok = 1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      if (data !== prev) hold_ok = 0;
      if (in_ready !== 1'b0 || busy !== 1'b1) ready_ok = 0;
    end
    n_cmp++;
    if (lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges required %0d", tag, lat, exp_lat);
    end
    n_cmp++;
    if (data !== ed || ovf !== eo) begin
      n_fail++;
      $display("FAIL %s result: got data=%h ovf=%b required data=%h ovf=%b", tag, data, ovf, ed, eo);
    end
    n_cmp++;
    if (!hold_ok || !ready_ok) begin
      n_fail++;
      $display("FAIL %s hold: data_held=%0d ready_low=%0d required 1 1", tag, hold_ok, ready_ok);
    end
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ready_in_done: in_ready=%b busy=%b required 1 0", tag, in_ready, busy);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_width: done=%b required 0", tag, done);
    end
    $display("txn %-10s value=%0d hex=%0d data=%h ovf=%b latency=%0d", tag, v, hex, data, ovf, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_value = '0; in_hex = 1'b0;
    wide_valid = 1'b0; wide_value = '0; wide_hex = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (data !== 32'h0 || ovf !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: data=%h ovf=%b done=%b busy=%b ready=%b required 0 0 0 0 1",
               data, ovf, done, busy, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("txn reset      data=%h ovf=%b ready=%b", data, ovf, in_ready);
  endtask

  task automatic test_directed();
    run_one(64'd12345678, 1'b0, "dec_basic");
    run_one(64'd99999999, 1'b0, "dec_max");
    run_one(64'd100000000, 1'b0, "dec_ovf");
    run_one(64'd0, 1'b0, "dec_zero");
    run_one(64'hFFFFFFFF, 1'b0, "dec_allone");
    run_one(64'hDEADBEEF, 1'b1, "hex_basic");
  endtask

  task automatic test_random();
    longint unsigned v;
    bit hex;
    for (int i = 0; i < 20; i++) begin
      hex = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: v = $urandom_range(0, 99999999);
        1: v = $urandom_range(0, 999);
        2: v = $urandom;
        default: v = $urandom_range(99999990, 100000009);
      endcase
      run_one(v, hex, "random");
    end
  endtask

  task automatic test_hex_wide();
    longint unsigned vals [2] = '{64'h1_0000_0001, 64'h0_1234_5678};
    logic [31:0] ed;
    logic        eo;
    int          lat;
    for (int i = 0; i < 2; i++) begin
      ref_conv(vals[i], 1'b1, ed, eo);
      @(negedge clk);
      wide_valid = 1'b1;
      wide_value = 36'(vals[i]);
      wide_hex   = 1'b1;
      @(posedge clk);
      #1;
      wide_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
        @(posedge clk);
        #1;
        if (wide_done === 1'b1) begin
          lat = k;
          break;
        end
      end
      n_cmp++;
      if (lat != 1 || wide_data !== ed || wide_ovf !== eo) begin
        n_fail++;
        $display("FAIL hex_wide: got lat=%0d data=%h ovf=%b required lat=1 data=%h ovf=%b",
                 lat, wide_data, wide_ovf, ed, eo);
      end
      $display("txn hex_wide   value=%h data=%h ovf=%b", vals[i], wide_data, wide_ovf);
    end
  endtask

  task automatic test_valid_held();
    logic [31:0] q_d [$];
    logic        q_o [$];
    logic [31:0] ed, last;
    logic        eo, acc;
    longint unsigned v;
    int          pops;
    pops = 0;
    last = data;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      v = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 99999999)) : 64'($urandom);
      in_valid = 1'b1;
      in_value = 32'(v);
      in_hex   = 1'b0;
      acc      = in_ready;
      @(posedge clk);
      if (acc) begin
        ref_conv(v, 1'b0, ed, eo);
        q_d.push_back(ed);
        q_o.push_back(eo);
      end
      #1;
      if (done === 1'b1) begin
        n_cmp++;
        if (q_d.size() == 0) begin
          n_fail++;
          $display("FAIL held_spurious: done with no accepted request");
        end else begin
          ed = q_d.pop_front();
          eo = q_o.pop_front();
          pops++;
          if (data !== ed || ovf !== eo) begin
            n_fail++;
            $display("FAIL held_result: got data=%h ovf=%b required data=%h ovf=%b", data, ovf, ed, eo);
          end
          $display("txn held       data=%h ovf=%b", data, ovf);
        end
        last = data;
      end else if (data !== last) begin
        n_cmp++;
        n_fail++;
        $display("FAIL held_hold: data=%h changed without done, required %h", data, last);
        last = data;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 60 && q_d.size() > 0; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        ed = q_d.pop_front();
        eo = q_o.pop_front();
        pops++;
        n_cmp++;
        if (data !== ed || ovf !== eo) begin
          n_fail++;
          $display("FAIL held_drain: got data=%h ovf=%b required data=%h ovf=%b", data, ovf, ed, eo);
        end
        $display("txn held_drain data=%h ovf=%b", data, ovf);
      end
    end
    n_cmp++;
    if (q_d.size() != 0 || pops < 3) begin
      n_fail++;
      $display("FAIL held_count: pending=%0d completed=%0d required 0 and >=3", q_d.size(), pops);
    end
  endtask

  task automatic test_abort();
    bit clean;
    @(negedge clk);
    while (!in_ready) @(negedge clk);
    in_valid = 1'b1;
    in_value = 32'd87654321;
    in_hex   = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (data !== 32'h0 || ovf !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_reset: data=%h ovf=%b done=%b ready=%b required 0 0 0 1",
               data, ovf, done, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    clean = 1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || data !== 32'h0 || in_ready !== 1'b1) clean = 0;
    end
    n_cmp++;
    if (!clean) begin
      n_fail++;
      $display("FAIL abort_quiet: done=%b data=%h ready=%b required 0 0 1", done, data, in_ready);
    end
    $display("txn abort      data=%h ovf=%b ready=%b", data, ovf, in_ready);
    run_one(64'd42, 1'b0, "after_abort");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hex_wide();
    test_random();
    test_valid_held();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
